// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/parity/stop framing into a
// one-entry holding register with parity, framing and overrun flags.
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_tick,
    input  logic       rx,
    input  logic [1:0] data_bit_num_i,
    input  logic       parity_en_i,
    input  logic       parity_type_i,
    input  logic       stop_bit_num_i,
    input  logic       rx_read_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_err_o,
    output logic       rts_n
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic       rx_meta_q, rx_s_q;
    logic [2:0] state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       frm_err_q, frm_err_d;
    logic       par_err_q, par_err_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] cfg_bits_q, cfg_bits_d;
    logic       cfg_par_en_q, cfg_par_en_d;
    logic       cfg_par_type_q, cfg_par_type_d;
    logic       cfg_stop_q, cfg_stop_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    logic       commit;
    logic       commit_ferr;
    logic       mid_tick, full_tick;
    logic       read_ok;

    assign mid_tick  = rx_tick && (tick_cnt_q == 4'd7);
    assign full_tick = rx_tick && (tick_cnt_q == 4'd15);

    always_comb begin
        state_d        = state_q;
        tick_cnt_d     = rx_tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        stop_cnt_d     = stop_cnt_q;
        frm_err_d      = frm_err_q;
        par_err_d      = par_err_q;
        shift_d        = shift_q;
        cfg_bits_d     = cfg_bits_q;
        cfg_par_en_d   = cfg_par_en_q;
        cfg_par_type_d = cfg_par_type_q;
        cfg_stop_d     = cfg_stop_q;
        commit         = 1'b0;
        commit_ferr    = frm_err_q;
        case (state_q)
            S_IDLE: begin
                tick_cnt_d = 4'd0;
                if (!rx_s_q) begin
                    state_d        = S_START;
                    bit_cnt_d      = 3'd0;
                    stop_cnt_d     = 1'b0;
                    frm_err_d      = 1'b0;
                    par_err_d      = 1'b0;
                    shift_d        = 8'd0;
                    cfg_bits_d     = data_bit_num_i;
                    cfg_par_en_d   = parity_en_i;
                    cfg_par_type_d = parity_type_i;
                    cfg_stop_d     = stop_bit_num_i;
                end
            end
            S_START: begin
                // Mid-bit qualification rejects glitches shorter than half a bit
                if (mid_tick) begin
                    tick_cnt_d = 4'd0;
                    state_d    = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (full_tick) begin
                    shift_d[bit_cnt_q] = rx_s_q;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == (3'd4 + {1'b0, cfg_bits_q}))
                        state_d = cfg_par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (full_tick) begin
                    par_err_d = (rx_s_q != ((^shift_q) ^ cfg_par_type_q));
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (full_tick) begin
                    if (!rx_s_q) frm_err_d = 1'b1;
                    if (stop_cnt_q == cfg_stop_q) begin
                        commit      = 1'b1;
                        commit_ferr = frm_err_q | ~rx_s_q;
                        state_d     = S_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A read in the commit cycle frees the register before the new load
    always_comb begin
        read_ok      = rx_read_i & rx_valid_q;
        rx_valid_d   = rx_valid_q & ~read_ok;
        overrun_d    = overrun_q & ~read_ok;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        if (commit) begin
            if (rx_valid_d) begin
                overrun_d = 1'b1;
            end else begin
                rx_valid_d   = 1'b1;
                rx_data_d    = shift_q;
                parity_err_d = par_err_q;
                frame_err_d  = commit_ferr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            tick_cnt_q   <= 4'd0;
            bit_cnt_q    <= 3'd0;
            stop_cnt_q   <= 1'b0;
            frm_err_q    <= 1'b0;
            par_err_q    <= 1'b0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            frm_err_q    <= frm_err_d;
            par_err_q    <= par_err_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Shift register and frame configuration are (re)loaded at every start
    always_ff @(posedge clk) begin
        shift_q        <= shift_d;
        cfg_bits_q     <= cfg_bits_d;
        cfg_par_en_q   <= cfg_par_en_d;
        cfg_par_type_q <= cfg_par_type_d;
        cfg_stop_q     <= cfg_stop_d;
    end

    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign parity_err_o  = parity_err_q;
    assign frame_err_o   = frame_err_q;
    assign overrun_err_o = overrun_q;
    assign rts_n         = rx_valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, expected characters queued by the
// stimulus and checked by an independent monitor as they appear.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_tick;
    logic       rx;
    logic [1:0] data_bit_num_i;
    logic       parity_en_i;
    logic       parity_type_i;
    logic       stop_bit_num_i;
    logic       rx_read_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_err_o;
    logic       rts_n;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_rx dut (
        .clk            (clk),
        .rst            (rst),
        .rx_tick        (rx_tick),
        .rx             (rx),
        .data_bit_num_i (data_bit_num_i),
        .parity_en_i    (parity_en_i),
        .parity_type_i  (parity_type_i),
        .stop_bit_num_i (stop_bit_num_i),
        .rx_read_i      (rx_read_i),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .parity_err_o   (parity_err_o),
        .frame_err_o    (frame_err_o),
        .overrun_err_o  (overrun_err_o),
        .rts_n          (rts_n)
    );

    always #5 clk = ~clk;

    // 16x tick: one cycle high every 4 clocks
    initial begin
        rx_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            rx_tick = 1'b1;
            @(negedge clk);
            rx_tick = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_char(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        exp_q.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (rx_tick !== 1'b1);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        @(negedge clk);
        rx = v;
        wait_ticks(n);
    endtask

    task automatic do_read();
        @(negedge clk);
        rx_read_i = 1'b1;
        @(negedge clk);
        rx_read_i = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] nb, input logic pen, input logic pt, input logic sb);
        @(negedge clk);
        data_bit_num_i = nb;
        parity_en_i    = pen;
        parity_type_i  = pt;
        stop_bit_num_i = sb;
    endtask

    // Sends one frame aligned to the tick grid; optionally pulses rx_read_i
    // exactly on the final stop-sample edge (8th tick of the last stop bit).
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                              input logic pt, input logic bad_par, input int nstop,
                              input logic stop_ok, input logic read_at_commit);
        logic [7:0] dm;
        dm = 8'd0;
        for (int i = 0; i < nbits; i++) dm[i] = d[i];
        wait_ticks(1);
        drive_bit(1'b0, 16);
        for (int i = 0; i < nbits; i++) drive_bit(dm[i], 16);
        if (pen) drive_bit((^dm) ^ pt ^ bad_par, 16);
        if (!stop_ok) begin
            drive_bit(1'b0, 9);
            drive_bit(1'b1, 16);
        end else begin
            for (int s = 0; s < nstop - 1; s++) drive_bit(1'b1, 16);
            if (read_at_commit) begin
                drive_bit(1'b1, 7);
                repeat (3) @(posedge clk);
                @(negedge clk);
                rx_read_i = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rx_read_i = 1'b0;
                wait_ticks(8);
            end else begin
                drive_bit(1'b1, 16);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk8({tag, "_data"}, rx_data_o, 8'h00);
        chk1({tag, "_valid"}, rx_valid_o, 1'b0);
        chk1({tag, "_perr"}, parity_err_o, 1'b0);
        chk1({tag, "_ferr"}, frame_err_o, 1'b0);
        chk1({tag, "_ovr"}, overrun_err_o, 1'b0);
        chk1({tag, "_rts_n"}, rts_n, 1'b0);
    endtask

    // Monitor: a new character is visible when valid rises, or when valid
    // stays high across an edge that carried a read (read/commit collision).
    initial begin
        logic rd, rs, prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            rd = rx_read_i;
            rs = rst;
            #1;
            if (!rs && rx_valid_o === 1'b1 && (!prev_valid || rd)) begin
                if (exp_q.size() == 0) begin
                    chk_int("unexpected_char", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk8("mon_data", rx_data_o, e.d);
                    chk1("mon_perr", parity_err_o, e.pe);
                    chk1("mon_ferr", frame_err_o, e.fe);
                end
            end
            prev_valid = (rx_valid_o === 1'b1);
        end
    end

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        rx_read_i = 1'b0;
        data_bit_num_i = 2'b11;
        parity_en_i = 1'b0;
        parity_type_i = 1'b0;
        stop_bit_num_i = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        wait_ticks(4);

        // 8N1 0xA5
        expect_char(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        chk1("8n1_valid", rx_valid_o, 1'b1);
        chk1("8n1_rts_n", rts_n, 1'b1);
        do_read();
        chk1("8n1_read_valid", rx_valid_o, 1'b0);
        chk1("8n1_read_rts_n", rts_n, 1'b0);

        // 5E2 with wrong parity bit
        set_cfg(2'b00, 1'b1, 1'b0, 1'b1);
        expect_char(8'h16, 1'b1, 1'b0);
        send_frame(8'h16, 5, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0);
        chk1("5e2_perr", parity_err_o, 1'b1);
        do_read();

        // glitch shorter than half a bit
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        wait_ticks(1);
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        chk1("glitch_valid", rx_valid_o, 1'b0);

        // framing error, then a clean frame clears the flag
        expect_char(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        wait_ticks(16);
        chk1("frame_ferr", frame_err_o, 1'b1);
        chk8("frame_data", rx_data_o, 8'h3C);
        do_read();
        expect_char(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        chk1("frame_clear_ferr", frame_err_o, 1'b0);
        do_read();

        // overrun: second character discarded
        expect_char(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        chk8("ovr_data", rx_data_o, 8'h11);
        chk1("ovr_flag", overrun_err_o, 1'b1);
        chk1("ovr_rts_n", rts_n, 1'b1);
        do_read();
        chk1("ovr_read_valid", rx_valid_o, 1'b0);
        chk1("ovr_read_flag", overrun_err_o, 1'b0);

        // read coincident with commit
        expect_char(8'h44, 1'b0, 1'b0);
        send_frame(8'h44, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        expect_char(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        chk1("coll_valid", rx_valid_o, 1'b1);
        chk8("coll_data", rx_data_o, 8'h55);
        chk1("coll_ovr", overrun_err_o, 1'b0);

        // reset in the middle of the data bits
        wait_ticks(1);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 24);
        @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        wait_ticks(4);
        expect_char(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        chk8("post_rst_data", rx_data_o, 8'h5A);
        do_read();

        wait_ticks(4);
        chk_int("pending_chars", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the APB-UART, directly downstream of the transmit line. It synchronises the incoming `rx` pin, detects and qualifies the start bit using a 16x oversampling tick from the baudrate generator, and shifts in 5–8 data bits, an optional parity bit and 1–2 stop bits. Each received character goes into a one-entry holding register that the register block reads. Parity, framing and overrun errors are flagged, and `rts_n` provides flow control to the peer.

## Interface
- No parameters; oversampling ratio fixed at 16, data width fixed at 8.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_tick`  in  1  1-cycle pulse at 16x baudrate, from the baudrate generator.
- `rx`  in  1  serial line from the peripheral; asynchronous, idles high.
- `data_bit_num_i`  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
- `parity_en_i`  in  1  parity bit present.
- `parity_type_i`  in  1  0=even, 1=odd.
- `stop_bit_num_i`  in  1  0=1 stop bit, 1=2 stop bits.
- `rx_read_i`  in  1  1-cycle pulse: register block consumed `rx_data_o`.
- `rx_data_o`  out  8  received character, LSB = first bit; unused MSBs are 0.
- `rx_valid_o`  out  1  holding register full.
- `parity_err_o`  out  1  parity error for the character in `rx_data_o`.
- `frame_err_o`  out  1  stop-bit error for the character in `rx_data_o`.
- `overrun_err_o`  out  1  sticky: a character was lost; cleared by `rx_read_i`.
- `rts_n`  out  1  active-low request-to-send; equals `rx_valid_o`, so it is high (not ready) while the holding register is full.

## Operation
- **Input synchroniser.** `rx` passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised value `rx_s`.
- **Configuration sampling.** Configuration inputs are sampled on the IDLE→START transition and held for the whole frame.
- **Tick counter.** A 4-bit counter `tick_cnt` advances only on `rx_tick`.
- **IDLE.** `rx_s`=0 → START, with `tick_cnt` cleared and the bit counter cleared.
- **START.** At the 8th `rx_tick` (mid-bit):
  - `rx_s`=0 → DATA, `tick_cnt` cleared.
  - `rx_s`=1 → false start, return to IDLE; no flags change.
- **DATA.** At the 16th `rx_tick`, sample `rx_s` into shift bit `bit_cnt`, then increment `bit_cnt`.
  - After N bits: go to PARITY if parity is enabled, otherwise to STOP.
- **PARITY.** Sample at the 16th tick. The error condition is: sampled bit != (^data XOR `parity_type_i`). Then go to STOP.
- **STOP.** Sample at each 16th tick.
  - Any sampled 0 sets the local frame error.
  - After 1 or 2 stop samples, commit and go to IDLE.
- **Commit, holding register empty:** load `rx_data_o`, `parity_err_o` and `frame_err_o`; set `rx_valid_o`.
- **Commit, holding register full (`rx_valid_o`=1):** discard the character, leave data and flags unchanged, set `overrun_err_o`.
- **Commit and `rx_read_i` in the same cycle:** the read takes effect first, then the new character loads. `rx_valid_o` stays 1 and no overrun is flagged.
- **Read.** `rx_read_i` with `rx_valid_o`=1 clears `rx_valid_o` and `overrun_err_o` on the next edge. `rx_read_i` while empty is ignored.
- **Break.** A frame error with all data bits 0 is committed as a normal character with `frame_err_o`=1.
- **Line held low.** After a committed frame the FSM returns to IDLE and immediately starts a new frame on the continued 0.

## Timing
- **Reset values:** `rx_data_o`=0, `rx_valid_o`=0, all error flags 0, `rts_n`=0, FSM=IDLE, counters 0.
  - Reset mid-frame aborts the frame; no partial commit.
- **Start detect latency:** 2 `clk` cycles from `rx` falling edge through the synchroniser.
- **Sample points:** data is sampled at 8+16k ticks after the start edge, i.e. at bit centres.
- **Commit:** occurs on the clock edge of the final stop-bit sample tick. `rx_valid_o` rises in the following cycle.
- **Frame length in ticks (excluding start):** 16 × (N + P + S), plus 8 for the start half-bit.
- **No `rx_tick`:** the FSM holds state indefinitely.

## Test plan
- **8N1 receive:** send 0xA5 at 16x ticks → `rx_valid_o`=1 and `rx_data_o`=0xA5, with no errors, one cycle after the stop sample. `rx_read_i` → `rx_valid_o`=0.
- **5E2 with a bad parity bit:** send 5'b10110 with parity bit 0 (even parity requires 1) and two stop bits → `rx_data_o`=0x16, `parity_err_o`=1.
- **Glitch rejection:** pulse `rx` low for 4 ticks → FSM returns to IDLE, `rx_valid_o` stays 0.
- **Framing error:** 8N1 frame of 0x3C with stop bit 0 → `rx_data_o`=0x3C, `frame_err_o`=1. A following good frame after reading clears `frame_err_o`.
- **Overrun:** receive 0x11, then 0x22 without reading → `rx_data_o`=0x11, `overrun_err_o`=1, `rts_n`=1. `rx_read_i` clears both `rx_valid_o` and `overrun_err_o`.
- **Read/commit collision and reset:**
  - `rx_read_i` coincident with the commit of 0x55 → `rx_valid_o` stays 1, `rx_data_o`=0x55, no overrun.
  - `rst` asserted mid-DATA → all outputs return to reset values and the next frame is received correctly.
